// File: rtl/led_status_ctrl.sv
// Front-panel LED controller: merges link, activity and sticky-error state into one
// LED pattern (off / steady / activity blink / error flash code) timed by blink_i.
module led_status_ctrl #(
  parameter int unsigned ACT_HOLD    = 8,
  parameter int unsigned ERR_FLASHES = 3,
  parameter int unsigned ERR_PAUSE   = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             blink_i,
  input  logic             link_up_i,
  input  logic             act_pulse_i,
  input  logic             err_i,
  input  logic             err_clear_i,
  output logic             led_o,
  output logic             err_active_o,
  output logic [CNT_W-1:0] err_count_o
);

  localparam int unsigned ACT_W   = $clog2(ACT_HOLD + 1);
  localparam int unsigned FLASH_W = $clog2(ERR_FLASHES + 1);
  localparam int unsigned PAUSE_W = $clog2(ERR_PAUSE + 1);

  localparam logic [ACT_W-1:0]   ACT_LOAD   = ACT_W'(ACT_HOLD);
  localparam logic [ACT_W-1:0]   ACT_ONE    = ACT_W'(1);
  localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(ERR_FLASHES);
  localparam logic [FLASH_W-1:0] FLASH_ONE  = FLASH_W'(1);
  localparam logic [PAUSE_W-1:0] PAUSE_LAST = PAUSE_W'(ERR_PAUSE);
  localparam logic [PAUSE_W-1:0] PAUSE_ONE  = PAUSE_W'(1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

  typedef enum logic [2:0] {
    StDown,
    StUp,
    StAct,
    StErrSync,
    StErrFlash,
    StErrPause
  } state_e;

  state_e             r_state;
  state_e             w_state_next;
  logic               r_blink_d;
  logic               w_tick;
  logic [ACT_W-1:0]   r_act_cnt;
  logic [ACT_W-1:0]   w_act_next;
  logic [FLASH_W-1:0] r_flash_cnt;
  logic [FLASH_W-1:0] w_flash_next;
  logic [FLASH_W-1:0] w_flash_inc;
  logic [PAUSE_W-1:0] r_pause_cnt;
  logic [PAUSE_W-1:0] w_pause_next;
  logic [PAUSE_W-1:0] w_pause_inc;
  logic               r_err_active;
  logic               w_err_active_next;
  logic [CNT_W-1:0]   r_err_count;
  logic [CNT_W-1:0]   w_err_count_next;
  logic               r_led;
  logic               w_led_next;
  logic               w_in_err;

  assign w_tick = blink_i & ~r_blink_d;

  // Activity hold counter; a pulse reload wins over a same-cycle tick decrement.
  always_comb begin
    w_act_next = r_act_cnt;
    if (!link_up_i) begin
      w_act_next = '0;
    end else if (act_pulse_i) begin
      w_act_next = ACT_LOAD;
    end else if (w_tick && (r_act_cnt != '0)) begin
      w_act_next = r_act_cnt - ACT_ONE;
    end
  end

  // Sticky error: a set in the same cycle as a clear keeps the error active.
  always_comb begin
    w_err_active_next = r_err_active;
    if (err_clear_i) begin
      w_err_active_next = 1'b0;
    end
    if (err_i) begin
      w_err_active_next = 1'b1;
    end
    w_err_count_next = r_err_count;
    if (err_i && (r_err_count != CNT_MAX)) begin
      w_err_count_next = r_err_count + CNT_ONE;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_flash_next = r_flash_cnt;
    w_pause_next = r_pause_cnt;
    w_flash_inc  = r_flash_cnt + FLASH_ONE;
    w_pause_inc  = r_pause_cnt + PAUSE_ONE;
    w_in_err     = (r_state == StErrSync) || (r_state == StErrFlash) ||
                   (r_state == StErrPause);

    if (w_err_active_next) begin
      if (!w_in_err) begin
        w_state_next = StErrSync;
      end else begin
        case (r_state)
          StErrSync: begin
            if (w_tick) begin
              w_state_next = StErrFlash;
              w_flash_next = '0;
            end
          end
          StErrFlash: begin
            if (w_tick) begin
              if (w_flash_inc == FLASH_LAST) begin
                w_state_next = StErrPause;
                w_pause_next = '0;
              end else begin
                w_flash_next = w_flash_inc;
              end
            end
          end
          StErrPause: begin
            if (w_tick) begin
              if (w_pause_inc == PAUSE_LAST) begin
                w_state_next = StErrFlash;
                w_flash_next = '0;
              end else begin
                w_pause_next = w_pause_inc;
              end
            end
          end
          default: w_state_next = StErrSync;
        endcase
      end
    end else if (!link_up_i) begin
      w_state_next = StDown;
    end else if (w_act_next != '0) begin
      w_state_next = StAct;
    end else begin
      w_state_next = StUp;
    end
  end

  // LED follows the next state and the blink level sampled this cycle.
  always_comb begin
    w_led_next = 1'b0;
    case (w_state_next)
      StUp:       w_led_next = 1'b1;
      StAct:      w_led_next = ~blink_i;
      StErrFlash: w_led_next = blink_i;
      default:    w_led_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state      <= StDown;
      r_blink_d    <= 1'b0;
      r_act_cnt    <= '0;
      r_flash_cnt  <= '0;
      r_pause_cnt  <= '0;
      r_err_active <= 1'b0;
      r_err_count  <= '0;
      r_led        <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_blink_d    <= blink_i;
      r_act_cnt    <= w_act_next;
      r_flash_cnt  <= w_flash_next;
      r_pause_cnt  <= w_pause_next;
      r_err_active <= w_err_active_next;
      r_err_count  <= w_err_count_next;
      r_led        <= w_led_next;
    end
  end

  assign led_o        = r_led;
  assign err_active_o = r_err_active;
  assign err_count_o  = r_err_count;

endmodule

// File: tb/tb_led_status_ctrl.sv
// Directed bench for led_status_ctrl (ACT_HOLD=4, ERR_FLASHES=3, ERR_PAUSE=2, blink 8 clk).
module tb_led_status_ctrl;

  logic       clk_i       = 1'b0;
  logic       reset_i     = 1'b1;
  logic       blink_i     = 1'b0;
  logic       link_up_i   = 1'b0;
  logic       act_pulse_i = 1'b0;
  logic       err_i       = 1'b0;
  logic       err_clear_i = 1'b0;
  logic       led_o;
  logic       err_active_o;
  logic [7:0] err_count_o;
  logic       led2_o;
  logic       err_active2_o;
  logic [1:0] err_count2_o;

  int checks = 0;
  int errors = 0;

  logic       blast    = 1'b0;
  logic       was_tick = 1'b0;
  logic [2:0] bcnt     = 3'd0;

  led_status_ctrl #(
    .ACT_HOLD(4), .ERR_FLASHES(3), .ERR_PAUSE(2), .CNT_W(8)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .blink_i(blink_i), .link_up_i(link_up_i),
    .act_pulse_i(act_pulse_i), .err_i(err_i), .err_clear_i(err_clear_i),
    .led_o(led_o), .err_active_o(err_active_o), .err_count_o(err_count_o)
  );

  led_status_ctrl #(
    .ACT_HOLD(4), .ERR_FLASHES(3), .ERR_PAUSE(2), .CNT_W(2)
  ) dut_sat (
    .clk_i(clk_i), .reset_i(reset_i), .blink_i(blink_i), .link_up_i(link_up_i),
    .act_pulse_i(act_pulse_i), .err_i(err_i), .err_clear_i(err_clear_i),
    .led_o(led2_o), .err_active_o(err_active2_o), .err_count_o(err_count2_o)
  );

  always #5 clk_i = ~clk_i;

  // Blink time base: 4 clk high, 4 clk low, updated 1 time unit after each edge.
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      bcnt    = bcnt + 3'd1;
      blink_i = bcnt[2];
    end
  end

  // Blink level seen at the edge that is `off` edges after a tick edge.
  function automatic logic bph(input int off);
    return ((off % 8) < 4);
  endfunction

  // One clock; outputs are sampled 2 units after the edge. Tracks whether that edge was a tick.
  task automatic cyc();
    logic bpre;
    logic rpre;
    bpre = blink_i;
    rpre = reset_i;
    @(posedge clk_i);
    #2;
    was_tick = bpre & ~blast & ~rpre;
    blast    = rpre ? 1'b0 : bpre;
  endtask

  task automatic wait_tick(input string tag);
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!was_tick && n < 20);
    if (!was_tick) begin
      checks++;
      errors++;
      $display("FAIL %s_tick_wait: no tick within %0d cycles, expected one", tag, n);
    end
  endtask

  task automatic test_reset();
    repeat (3) cyc();
    checks++;
    if (led_o !== 1'b0) begin
      errors++; $display("FAIL reset_led: got %b expected 0", led_o);
    end
    checks++;
    if (err_active_o !== 1'b0) begin
      errors++; $display("FAIL reset_err_active: got %b expected 0", err_active_o);
    end
    checks++;
    if (err_count_o !== 8'd0) begin
      errors++; $display("FAIL reset_err_count: got %0d expected 0", err_count_o);
    end
    checks++;
    if (led2_o !== 1'b0 || err_count2_o !== 2'd0) begin
      errors++; $display("FAIL reset_sat_dut: got led %b cnt %0d expected 0 0", led2_o, err_count2_o);
    end
    reset_i   = 1'b0;
    link_up_i = 1'b1;
    cyc();
    checks++;
    if (led_o !== 1'b1) begin
      errors++; $display("FAIL link_up_led: got %b expected 1", led_o);
    end
    link_up_i = 1'b0;
    cyc();
    checks++;
    if (led_o !== 1'b0) begin
      errors++; $display("FAIL link_down_led: got %b expected 0", led_o);
    end
  endtask

  task automatic test_activity();
    logic exp;
    link_up_i = 1'b1;
    wait_tick("act");
    // Pulses at offsets 1 and 17 (after 2 ticks); hold ends at the 4th tick after the second.
    for (int off = 1; off <= 50; off++) begin
      act_pulse_i = (off == 1) || (off == 17);
      cyc();
      act_pulse_i = 1'b0;
      exp = (off < 48) ? ~bph(off) : 1'b1;
      checks++;
      if (led_o !== exp) begin
        errors++; $display("FAIL act_extend_off%0d: got %b expected %b", off, led_o, exp);
      end
    end
    wait_tick("act_coinc");
    // Pulse lands on the tick edge at offset 8: reload to 4, so UP only at offset 40.
    for (int off = 1; off <= 42; off++) begin
      act_pulse_i = (off == 8);
      cyc();
      act_pulse_i = 1'b0;
      exp = (off < 8) ? 1'b1 : ((off < 40) ? ~bph(off) : 1'b1);
      checks++;
      if (led_o !== exp) begin
        errors++; $display("FAIL act_coinc_off%0d: got %b expected %b", off, led_o, exp);
      end
    end
  endtask

  task automatic test_act_link_down();
    link_up_i = 1'b0;
    cyc();
    act_pulse_i = 1'b1;
    cyc();
    act_pulse_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (led_o !== 1'b0) begin
        errors++; $display("FAIL act_linkdown_%0d: got %b expected 0", i, led_o);
      end
      cyc();
    end
    link_up_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc();
      checks++;
      if (led_o !== 1'b1) begin
        errors++; $display("FAIL act_linkup_steady_%0d: got %b expected 1", i, led_o);
      end
    end
  endtask

  task automatic test_error_code();
    logic exp;
    wait_tick("err");
    for (int off = 1; off <= 60; off++) begin
      err_i = (off == 1);
      cyc();
      err_i = 1'b0;
      // SYNC until offset 8, flashes through 31, pause 32..47, next burst from 48.
      if (off < 8)       exp = 1'b0;
      else if (off < 32) exp = bph(off);
      else if (off < 48) exp = 1'b0;
      else               exp = bph(off);
      checks++;
      if (led_o !== exp || err_active_o !== 1'b1 || err_count_o !== 8'd1) begin
        errors++;
        $display("FAIL err_code_off%0d: got led %b act %b cnt %0d expected %b 1 1",
                 off, led_o, err_active_o, err_count_o, exp);
      end
    end
    err_clear_i = 1'b1;
    cyc();
    err_clear_i = 1'b0;
    checks++;
    if (led_o !== 1'b1 || err_active_o !== 1'b0 || err_count_o !== 8'd1) begin
      errors++;
      $display("FAIL err_clear: got led %b act %b cnt %0d expected 1 0 1",
               led_o, err_active_o, err_count_o);
    end
  endtask

  task automatic test_simultaneous();
    err_i       = 1'b1;
    err_clear_i = 1'b1;
    cyc();
    err_i       = 1'b0;
    err_clear_i = 1'b0;
    checks++;
    if (err_active_o !== 1'b1 || err_count_o !== 8'd2 || led_o !== 1'b0) begin
      errors++;
      $display("FAIL set_clear_same: got act %b cnt %0d led %b expected 1 2 0",
               err_active_o, err_count_o, led_o);
    end
    wait_tick("sim");
    checks++;
    if (led_o !== 1'b1) begin
      errors++; $display("FAIL flash_start: got %b expected 1", led_o);
    end
    err_i = 1'b1;
    cyc();
    err_i = 1'b0;
    checks++;
    if (led_o !== 1'b1 || err_count_o !== 8'd3) begin
      errors++;
      $display("FAIL err_no_restart: got led %b cnt %0d expected 1 3", led_o, err_count_o);
    end
    #1;
    reset_i = 1'b1;
    #1;
    checks++;
    if (led_o !== 1'b0 || err_active_o !== 1'b0 || err_count_o !== 8'd0) begin
      errors++;
      $display("FAIL async_reset: got led %b act %b cnt %0d expected 0 0 0",
               led_o, err_active_o, err_count_o);
    end
    repeat (2) cyc();
    reset_i   = 1'b0;
    link_up_i = 1'b0;
    cyc();
    checks++;
    if (led_o !== 1'b0 || err_active_o !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_down: got led %b act %b expected 0 0", led_o, err_active_o);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_sat;
    err_i = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      exp_sat = (i < 3) ? 2'(i) : 2'd3;
      checks++;
      if (err_count2_o !== exp_sat || err_count_o !== 8'(i) || err_active2_o !== 1'b1) begin
        errors++;
        $display("FAIL sat_cycle%0d: got sat %0d wide %0d act %b expected %0d %0d 1",
                 i, err_count2_o, err_count_o, err_active2_o, exp_sat, i);
      end
    end
    err_i       = 1'b0;
    err_clear_i = 1'b1;
    cyc();
    err_clear_i = 1'b0;
    checks++;
    if (err_active_o !== 1'b0 || err_count_o !== 8'd6 || err_count2_o !== 2'd3) begin
      errors++;
      $display("FAIL clear_keeps_count: got act %b cnt %0d sat %0d expected 0 6 3",
               err_active_o, err_count_o, err_count2_o);
    end
  endtask

  initial begin
    test_reset();
    test_activity();
    test_act_link_down();
    test_error_code();
    test_simultaneous();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_status_ctrl.md
Name: led_status_ctrl

Overview:
- Front-panel LED controller that directly consumes the slow square-wave blink time base from the blink driver.
- Merges link state, per-packet activity pulses and a sticky error condition into one LED pattern: off, steady, activity blink, or repeating error flash code.
- Also keeps a saturating error-event counter for debug readout.

Parameters:
- ACT_HOLD, 8, number of blink ticks the activity pattern persists after the last act_pulse_i
- ERR_FLASHES, 3, flashes per error code burst (>=1)
- ERR_PAUSE, 4, blink ticks of LED-off pause between error bursts (>=1)
- CNT_W, 8, width of err_count_o

Ports:
- clk_i  in  1  system clock; blink_i is in the same domain
- reset_i  in  1  asynchronous, active-high reset
- blink_i  in  1  blink time base (square wave)
- link_up_i  in  1  level, link established
- act_pulse_i  in  1  single-cycle activity event
- err_i  in  1  error event (any high cycle counts as one event)
- err_clear_i  in  1  single-cycle clear of sticky error
- led_o  out  1  LED drive, registered
- err_active_o  out  1  sticky error flag, registered
- err_count_o  out  CNT_W  saturating count of cycles with err_i high

Behaviour:
- Tick: blink_d registers blink_i; tick = blink_i & ~blink_d (rising edge only).
- Reset (async): blink_d=0, state=DOWN, led_o=0, err_active_o=0, err_count_o=0, all internal counters 0.
- Latency: inputs sampled at edge k are reflected in state, led_o and err_active_o after edge k. led_o is computed from the next state and the current blink_i.
- Top-level states, in priority order ERR > DOWN > ACT > UP:
  - DOWN: link_up_i=0 and no error; led_o=0. act_pulse_i is ignored and act_cnt is forced to 0.
  - UP: link up, act_cnt=0; led_o=1.
  - ACT: link up, act_cnt>0; led_o=~blink_i.
  - ERR: err_active_o=1; runs the flash-code substates below.
- Activity counter:
  - act_pulse_i with link up loads act_cnt=ACT_HOLD.
  - Otherwise each tick decrements act_cnt while it is >0.
  - Pulse and tick in the same cycle: the reload wins.
  - ACT->UP in the cycle act_cnt reaches 0.
- Error latch:
  - err_i=1 sets err_active_o and increments err_count_o, saturating at 2^CNT_W-1.
  - err_clear_i clears err_active_o.
  - err_i and err_clear_i in the same cycle: the error stays set and the count increments.
  - err_count_o is cleared only by reset.
- ERR substates:
  - SYNC: entered on any transition into ERR. led_o=0. On the next tick go to FLASH with flash_cnt=0.
  - FLASH: led_o=blink_i. Each tick increments flash_cnt. On the tick where flash_cnt would reach ERR_FLASHES, go to PAUSE with pause_cnt=0 and led_o=0.
  - PAUSE: led_o=0. Each tick increments pause_cnt. On the tick where pause_cnt would reach ERR_PAUSE, go to FLASH with flash_cnt=0; led_o follows blink_i (=1) immediately.
  - err_i while already in ERR does not restart the sequence.
- Leaving ERR (err_clear_i accepted): next state is DOWN, ACT or UP per current link_up_i and act_cnt, in the same cycle. act_cnt keeps running during ERR.
- Link drop mid-ACT: immediate DOWN, act_cnt=0.
- Counter widths are sized as clog2(param+1). Decrements never underflow.

Test Plan:
Bench setup for all scenarios: ACT_HOLD=4, ERR_FLASHES=3, ERR_PAUSE=2; blink_i period 8 clk (4 high, 4 low).

1. Reset and link: hold reset_i for 3 cycles -> led_o=0, err_active_o=0, err_count_o=0. Raise link_up_i -> led_o=1 one edge later. Drop link_up_i -> led_o=0 one edge later.
2. Activity with link up: one act_pulse_i -> led_o=~blink_i for exactly 4 ticks, then steady 1. A second pulse after 2 ticks -> pattern extends to 4 ticks past the second pulse. A pulse coincident with a tick -> act_cnt=4, not 3.
3. Activity with link down: act_pulse_i while link_up_i=0 -> led_o stays 0. Raising link afterwards -> led_o steady 1, no blinking.
4. Error code: a one-cycle err_i -> err_active_o=1, err_count_o=1, led_o=0 until the next tick. Then exactly 3 high pulses of 4 clk each, then 0 for 16 clk, then repeat. err_clear_i with link up -> led_o=1 next edge.
5. Simultaneous events: err_i and err_clear_i in the same cycle -> err_active_o stays 1, count increments. Assert reset_i mid-FLASH -> all outputs 0 immediately (asynchronous), state DOWN.
6. Saturation: with CNT_W=2, hold err_i high for 6 cycles -> err_count_o reads 1,2,3,3,3,3.
